csel_pipe_adder: RTL and testbench
==================================

# csel_pipe_adder

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready flow control on both sides. It generalises the 4-bit combinational carry-select adder to any `WIDTH` split into `BLK`-bit select blocks. It adds a subtract mode, a signed-overflow flag and backpressure handling, so it can sit directly in a streaming datapath between a producer and a consumer.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must be a multiple of `BLK`, otherwise elaboration error.
- `BLK`, 4, bits per carry-select block; `NUM_BLK = WIDTH/BLK` blocks.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `x`  input  WIDTH  operand A.
- `y`  input  WIDTH  operand B.
- `carry`  input  1  carry-in; ignored when `sub`=1.
- `sub`  input  1  0: s = x+y+carry; 1: s = x-y (x + ~y + 1).
- `in_valid`  input  1  operands/controls valid.
- `in_ready`  output  1  block accepts a beat this cycle.
- `s`  output  WIDTH  result.
- `cout`  output  1  carry-out; in subtract mode 1 means no borrow.
- `ovf`  output  1  two's-complement overflow.
- `out_valid`  output  1  `s`/`cout`/`ovf` valid.
- `out_ready`  input  1  consumer accepts the result.

## Operation
- Operand conditioning (stage 1 input): `yb = sub ? ~y : y`; `ci = sub ? 1 : carry`.
- Stage 1 (registered, flag `v1`):
  - Block 0: one `BLK`-bit sum and carry using `ci`.
  - Blocks 1..NUM_BLK-1: two sums/carries each, precomputed for carry-in 0 and 1.
  - Also registers `x[WIDTH-1]` and `yb[WIDTH-1]` for the overflow calculation.
- Stage 2 (registered, flag `v2`): carry-select chain.
  - Carry into block 1 is block 0's carry-out.
  - For k≥1, carry into block k selects that block's sum and carry-out from the cin=0 or cin=1 pair; the selected carry-out feeds block k+1.
  - `cout` is the carry-out of the last block.
  - `ovf = (xm == ybm) && (s[WIDTH-1] != xm)`, where `xm`/`ybm` are the stage-1 sign bits.
- Flow control (bubble-collapsing, no skid buffer):
  - `adv2 = !v2 || out_ready`.
  - `adv1 = !v1 || adv2`.
  - `in_ready = adv1`.
  - A beat transfers on input when `in_valid && in_ready`, and on output when `out_valid && out_ready`.
  - Stage 2 loads when `adv2`. `v2 <= v1` on load; data is captured only when `v1`=1.
  - Stage 1 loads when `adv1`. `v1 <= in_valid && in_ready`.
  - A stage whose valid flag is 0 holds its data; contents are don't-care.
- Output stability: while `out_valid && !out_ready`, `s`, `cout` and `ovf` hold unchanged.
- Ordering: results leave in acceptance order, with no drops and no duplicates.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (asynchronous on `rst` rise, held while high):
  - `v1`, `v2`, `out_valid`, `s`, `cout`, `ovf` and all stage-1 registers go to 0.
  - `in_ready` = 1 (combinational from flags).
- Latency: a beat accepted at edge N shows on `out_valid`/`s` after edge N+1, so it is visible in cycle N+2.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Backpressure: with `out_ready` held low and both stages full, `in_ready`=0 in the same cycle (combinational path `out_ready` → `in_ready`).
- Simultaneous events:
  - Input and output transfer in the same cycle with both stages full: both stages advance and nothing is lost.
  - A new beat entering stage 1 while stage 1 moves to stage 2 is legal.
- Reset mid-operation: in-flight beats are discarded and nothing is emitted after reset release until new input is accepted.
- Critical path: the stage-2 select chain of `NUM_BLK` mux levels plus the final overflow compare; stage 1 is a `BLK`-bit ripple.

## Structure
- Package `csel_pkg`: `NUM_BLK` derivation function and the `WIDTH % BLK` legality check macro/function.
- Sub-module `csel_block` (parameter `BLK`):
  - Inputs `a`, `b`.
  - Outputs `sum0`, `c0`, `sum1`, `c1` (ripple adders with cin=0 and cin=1).
  - Instantiated once per block via generate; block 0 uses `sum1`/`c1` or `sum0`/`c0` selected by `ci` before the stage-1 register.
- Top: stage registers, select chain, flow-control logic.

## Test plan
All scenarios use WIDTH=16, BLK=4 unless noted.
1. Add: x=0x0001, y=0x0006, carry=0, sub=0 → two cycles later s=0x0007, cout=0, ovf=0.
2. Full propagate: x=0xFFFF, y=0x0000, carry=1 → s=0x0000, cout=1; 0x7FFF+0x0001 → s=0x8000, ovf=1, cout=0.
3. Subtract:
   - 0x0005-0x0007 → s=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → s=0x7FFF, cout=1, ovf=1.
   - `carry`=1 has no effect on either result.
4. Backpressure: stream 5 beats with `in_valid`=1 and `out_ready`=0 for 4 cycles → exactly 2 beats accepted, `in_ready`=0, `s` stable. Then raise `out_ready` → all 5 results emerge in order at 1/cycle.
5. Reset mid-stream: assert `rst` with `v1`=`v2`=1 → `out_valid`=0, `s`=0 immediately (asynchronous). No stale result appears after release.
6. Random sweep at WIDTH=32, BLK=8, with random `in_valid`/`out_ready` throttling, 10k beats → every result matches a reference `{cout,s}` and `ovf` model, order preserved.

Source files
------------

// File: rtl/csel_pkg.sv
// rtl/csel_pkg.sv - shared sizing helpers for the carry-select pipelined adder
package csel_pkg;

  function automatic int num_blk(input int width, input int blk);
    return width / blk;
  endfunction

  // Legal only when the operand splits into whole, non-empty blocks.
  function automatic bit width_ok(input int width, input int blk);
    return (blk > 0) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/csel_block.sv
// rtl/csel_block.sv - one carry-select block: BLK-bit sums for carry-in 0 and 1
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic           c0,
  output logic [BLK-1:0] sum1,
  output logic           c1
);

  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - two-stage carry-select adder/subtractor with valid/ready flow control
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NUM_BLK = num_blk(WIDTH, BLK);

  if (!width_ok(WIDTH, BLK)) begin : g_bad_width
    $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  logic             v1;
  logic             v2;
  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] yb;
  logic             ci;

  logic [NUM_BLK-1:0][BLK-1:0] b_sum0;
  logic [NUM_BLK-1:0][BLK-1:0] b_sum1;
  logic [NUM_BLK-1:0]          b_c0;
  logic [NUM_BLK-1:0]          b_c1;

  logic [NUM_BLK-1:0][BLK-1:0] n_sum0;
  logic [NUM_BLK-1:0][BLK-1:0] n_sum1;
  logic [NUM_BLK-1:0]          n_c0;
  logic [NUM_BLK-1:0]          n_c1;

  logic [NUM_BLK-1:0][BLK-1:0] r_sum0;
  logic [NUM_BLK-1:0][BLK-1:0] r_sum1;
  logic [NUM_BLK-1:0]          r_c0;
  logic [NUM_BLK-1:0]          r_c1;
  logic                        xm;
  logic                        ybm;

  logic [NUM_BLK-1:0][BLK-1:0] sel_sum;
  logic                        sel_c;
  logic [WIDTH-1:0]            s_next;
  logic                        ovf_next;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  assign yb = sub ? ~y : y;
  assign ci = sub ? 1'b1 : carry;

  for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
    csel_block #(.BLK(BLK)) u_blk (
      .a    (x[g*BLK +: BLK]),
      .b    (yb[g*BLK +: BLK]),
      .sum0 (b_sum0[g]),
      .c0   (b_c0[g]),
      .sum1 (b_sum1[g]),
      .c1   (b_c1[g])
    );
  end

  // Block 0 already knows its carry-in, so both of its slots hold the resolved
  // result and the stage-2 chain can treat every block identically.
  always_comb begin
    n_sum0    = b_sum0;
    n_sum1    = b_sum1;
    n_c0      = b_c0;
    n_c1      = b_c1;
    n_sum0[0] = ci ? b_sum1[0] : b_sum0[0];
    n_sum1[0] = ci ? b_sum1[0] : b_sum0[0];
    n_c0[0]   = ci ? b_c1[0] : b_c0[0];
    n_c1[0]   = ci ? b_c1[0] : b_c0[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      r_sum0 <= '0;
      r_sum1 <= '0;
      r_c0   <= '0;
      r_c1   <= '0;
      xm     <= 1'b0;
      ybm    <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        r_sum0 <= n_sum0;
        r_sum1 <= n_sum1;
        r_c0   <= n_c0;
        r_c1   <= n_c1;
        xm     <= x[WIDTH-1];
        ybm    <= yb[WIDTH-1];
      end
    end
  end

  always_comb begin
    sel_sum = '0;
    sel_c   = 1'b0;
    for (int k = 0; k < NUM_BLK; k++) begin
      sel_sum[k] = sel_c ? r_sum1[k] : r_sum0[k];
      sel_c      = sel_c ? r_c1[k] : r_c0[k];
    end
  end

  assign s_next   = sel_sum;
  assign ovf_next = (xm == ybm) && (s_next[WIDTH-1] != xm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s    <= s_next;
        cout <= sel_c;
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// tb/tb_csel_pipe_adder.sv - table-driven and scoreboard bench for csel_pipe_adder
module tb_csel_pipe_adder;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        carry;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } nres_t;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } wres_t;

  logic        clk;
  logic        rst;
  logic [15:0] x, y, s;
  logic        carry, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

  logic [31:0] wx, wy, ws;
  logic        wcarry, wsub, win_valid, win_ready, wcout, wovf, wout_valid, wout_ready;

  logic [15:0] exp_s;
  logic        exp_cout, exp_ovf;

  int vectors     = 0;
  int miscompares = 0;
  int n_out       = 0;
  int w_in_cnt    = 0;
  int w_out_cnt   = 0;
  bit w_fire      = 1'b0;

  nres_t sb[$];
  wres_t wsb[$];
  vec_t  tbl[15];

  csel_pipe_adder u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .carry(carry), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  csel_pipe_adder #(.WIDTH(32), .BLK(8)) u_wide (
    .clk(clk), .rst(rst), .x(wx), .y(wy), .carry(wcarry), .sub(wsub),
    .in_valid(win_valid), .in_ready(win_ready), .s(ws), .cout(wcout), .ovf(wovf),
    .out_valid(wout_valid), .out_ready(wout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wres_t wmodel(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic sb_mode);
    wres_t r;
    logic signed [33:0] sr;
    logic [32:0] u;
    if (sb_mode) begin
      sr     = $signed({{2{a[31]}}, a}) - $signed({{2{b[31]}}, b});
      u      = {1'b0, a} - {1'b0, b};
      r.cout = (a >= b);
    end else begin
      sr     = $signed({{2{a[31]}}, a}) + $signed({{2{b[31]}}, b}) + $signed({33'b0, c});
      u      = {1'b0, a} + {1'b0, b} + {32'b0, c};
      r.cout = u[32];
    end
    r.s   = u[31:0];
    r.ovf = (sr[33:31] != 3'b000) && (sr[33:31] != 3'b111);
    return r;
  endfunction

  // Scoreboards: push on accepted input, pop and compare on delivered output.
  always @(negedge clk) begin
    nres_t e;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got s=%h with no beat outstanding", s);
      end else begin
        e = sb.pop_front();
        check("result16", {47'b0, s, cout, ovf}, {47'b0, e.s, e.cout, e.ovf});
      end
    end
    if (in_valid && in_ready) sb.push_back('{exp_s, exp_cout, exp_ovf});
  end

  always @(negedge clk) begin
    wres_t e;
    if (wout_valid && wout_ready) begin
      w_out_cnt++;
      if (wsb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output32: got s=%h with no beat outstanding", ws);
      end else begin
        e = wsb.pop_front();
        check("result32", {30'b0, ws, wcout, wovf}, {30'b0, e.s, e.cout, e.ovf});
      end
    end
    w_fire = win_valid && win_ready;
    if (w_fire) begin
      wsb.push_back(wmodel(wx, wy, wcarry, wsub));
      w_in_cnt++;
    end
  end

  task automatic set_beat(input vec_t v);
    x = v.x; y = v.y; carry = v.carry; sub = v.sub;
    exp_s = v.s; exp_cout = v.cout; exp_ovf = v.ovf;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat transfers.
  task automatic send(input vec_t v);
    int c;
    c = 0;
    set_beat(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    acc, cnt, base, bad, cyc;
    bit    fire;
    logic [15:0] s_hold;

    tbl[0]  = '{16'h0001, 16'h0006, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[12] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[13] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[14] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; carry = 1'b0; sub = 1'b0;
    exp_s = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    wx = '0; wy = '0; wcarry = 1'b0; wsub = 1'b0; win_valid = 1'b0; wout_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_result",    {47'b0, s, cout, ovf}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible in cycle N+2.
    set_beat(tbl[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_edge_n1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge_n2", {47'b0, out_valid, s}, {47'b0, 1'b1, 16'h0007});
    drain("drain_latency");

    for (int i = 0; i < 15; i++) send(tbl[i]);
    drain("drain_table");

    // Backpressure with beats tbl[7..11].
    out_ready = 1'b0;
    cnt = 7;
    set_beat(tbl[cnt]);
    in_valid = 1'b1;
    acc = 0;
    s_hold = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      fire = in_ready;
      if (fire) acc++;
      if (c == 2) s_hold = s;
      @(posedge clk);
      #1;
      if (fire) begin
        cnt++;
        set_beat(tbl[cnt]);
      end
    end
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_first_s", 64'(s_hold), 64'(tbl[7].s));
    check("bp_s_stable", {47'b0, out_valid, s}, {47'b0, 1'b1, s_hold});
    base = n_out;
    out_ready = 1'b1;
    bad = 0;
    fork
      begin
        for (int i = 9; i < 12; i++) send(tbl[i]);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (out_valid && out_ready) bad++;
        end
      end
    join
    check("bp_one_per_cycle", 64'(bad), 64'd5);
    drain("drain_bp");
    check("bp_total_out", 64'(n_out - base), 64'd5);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[4]);
    check("rst_mid_pre", {62'b0, v_pair(out_valid, in_ready)}, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_result", {47'b0, s, cout, ovf}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("rst_no_stale", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    send(tbl[13]);
    drain("drain_after_rst");

    // Randomly throttled 32-bit sweep.
    cyc = 0;
    while (w_in_cnt < 10000 && cyc < 60000) begin
      if (!win_valid || w_fire) begin
        if ($urandom_range(0, 9) < 7) begin
          win_valid = 1'b1;
          case ($urandom_range(0, 7))
            0: wx = 32'h8000_0000;
            1: wx = 32'h7FFF_FFFF;
            2: wx = 32'hFFFF_FFFF;
            default: wx = $urandom;
          endcase
          case ($urandom_range(0, 7))
            0: wy = 32'h0000_0001;
            1: wy = 32'h8000_0000;
            2: wy = 32'h0000_0000;
            default: wy = $urandom;
          endcase
          wcarry = 1'($urandom_range(0, 1));
          wsub   = 1'($urandom_range(0, 1));
        end else begin
          win_valid = 1'b0;
        end
      end
      wout_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      cyc++;
    end
    win_valid  = 1'b0;
    wout_ready = 1'b1;
    check("sweep_accepted", 64'(w_in_cnt), 64'd10000);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wsb.size() == 0 && !wout_valid) break;
    end
    check("sweep_delivered", 64'(w_out_cnt), 64'd10000);
    check("sweep_drained", 64'(wsb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [1:0] v_pair(input logic a, input logic b);
    return {a, b};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
